// File: rtl/line_pkg.sv
// Shared types for the line sequencer: command record, FSM states and
// the on-screen test applied to incoming commands.
package line_pkg;

   localparam int COORD_W = 11;

   typedef struct packed {
      logic [COORD_W-1:0] x0;
      logic [COORD_W-1:0] y0;
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] y1;
      logic               color;
   } line_cmd_t;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} seq_state_t;

   function automatic logic on_screen(line_cmd_t c, int w, int h);
      return (int'(c.x0) < w) && (int'(c.x1) < w) &&
             (int'(c.y0) < h) && (int'(c.y1) < h);
   endfunction

endpackage

// File: rtl/line_sequencer_if.sv
// Command port and drawer port of the line sequencer. The slave side is the
// sequencer; the master side is the command source plus the line drawer.
interface line_sequencer_if;
   import line_pkg::*;

   logic               cmd_valid;
   logic               cmd_ready;
   logic [COORD_W-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
   logic               cmd_color;

   logic               drw_reset;
   logic [COORD_W-1:0] drw_x0, drw_y0, drw_x1, drw_y1;
   logic               drw_done;
   logic               pix_color;

   modport master (
      output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, drw_done,
      input  cmd_ready, drw_reset, drw_x0, drw_y0, drw_x1, drw_y1, pix_color
   );

   modport slave (
      input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, drw_done,
      output cmd_ready, drw_reset, drw_x0, drw_y0, drw_x1, drw_y1, pix_color
   );

endinterface

// File: rtl/line_cmd_fifo.sv
// DEPTH-entry circular buffer of line commands, no bypass.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module line_cmd_fifo
   import line_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic      clk,
   input  logic      reset_n,
   input  logic      push,
   input  logic      pop,
   input  line_cmd_t din,
   output line_cmd_t dout,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);

   line_cmd_t     mem [DEPTH];
   logic [AW:0]   wp, rp;
   logic          do_push, do_pop;

   assign empty   = (wp == rp);
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rp[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wp[AW-1:0]] <= din;
   end

endmodule

// File: rtl/line_sequencer.sv
// Command-queue front end for the line drawer: buffers commands, issues them
// one at a time with the drawer held in reset between lines, and keeps status.
module line_sequencer
   import line_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int TIMEOUT  = 4096
)(
   input  logic            clk,
   input  logic            reset_n,
   line_sequencer_if.slave bus,
   output logic            busy,
   output logic [15:0]     lines_done,
   output logic            dropped,
   output logic            timeout_err
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   seq_state_t    state, state_d;
   line_cmd_t     cmd_in, head, cur;
   logic          full, empty;
   logic          accept, in_range, push, pop;
   logic          line_fin, line_abort;
   logic [TW-1:0] tcnt;
   logic          drw_reset_q;

   assign cmd_in   = {bus.cmd_x0, bus.cmd_y0, bus.cmd_x1, bus.cmd_y1, bus.cmd_color};
   assign in_range = on_screen(cmd_in, SCREEN_W, SCREEN_H);
   assign accept   = bus.cmd_valid && bus.cmd_ready;
   assign push     = accept && in_range;
   assign pop      = (state == LOAD);

   line_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (cmd_in),
      .dout    (head),
      .full    (full),
      .empty   (empty)
   );

   // drw_done is only meaningful in RUN and beats a simultaneous timeout.
   always_comb begin
      state_d    = state;
      line_fin   = 1'b0;
      line_abort = 1'b0;
      case (state)
         IDLE: if (!empty) state_d = LOAD;
         LOAD: state_d = RUN;
         RUN: begin
            if (bus.drw_done) begin
               line_fin = 1'b1;
               state_d  = IDLE;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               line_abort = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         drw_reset_q <= 1'b1;
         cur         <= '0;
         tcnt        <= '0;
         lines_done  <= '0;
         dropped     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_d;
         drw_reset_q <= (state_d != RUN);
         if (state == LOAD) begin
            cur  <= head;
            tcnt <= '0;
         end else if (state == RUN) begin
            tcnt <= tcnt + 1'b1;
         end
         if (line_fin)              lines_done  <= lines_done + 16'd1;
         if (line_abort)            timeout_err <= 1'b1;
         if (accept && !in_range)   dropped     <= 1'b1;
      end
   end

   assign bus.cmd_ready = !full;
   assign bus.drw_reset = drw_reset_q;
   assign bus.drw_x0    = cur.x0;
   assign bus.drw_y0    = cur.y0;
   assign bus.drw_x1    = cur.x1;
   assign bus.drw_y1    = cur.y1;
   assign bus.pix_color = cur.color;
   assign busy          = !empty || (state != IDLE);

endmodule

// File: tb/tb_line_sequencer.sv
// Self-checking bench for line_sequencer: a directed table, hand-written
// corner sequences and random traffic, all shadowed by a queue-based model.
module tb_line_sequencer;
   import line_pkg::*;

   localparam int DEPTH = 4;
   localparam int SW    = 640;
   localparam int SH    = 480;
   localparam int TO    = 16;
   localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        busy;
   logic [15:0] lines_done;
   logic        dropped, timeout_err;

   always #5 clk = ~clk;

   line_sequencer_if bus();

   line_sequencer #(.DEPTH(DEPTH), .SCREEN_W(SW), .SCREEN_H(SH), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .busy        (busy),
      .lines_done  (lines_done),
      .dropped     (dropped),
      .timeout_err (timeout_err)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: a command queue plus the line currently handed out.
   line_cmd_t   m_q[$];
   line_cmd_t   m_cur;
   int          m_ph, m_cnt;
   logic [15:0] m_lines;
   bit          m_drop, m_tout;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic line_cmd_t mk(input int x0, input int y0, input int x1,
                                    input int y1, input bit c);
      line_cmd_t r;
      r.x0 = 11'(x0); r.y0 = 11'(y0); r.x1 = 11'(x1); r.y1 = 11'(y1); r.color = c;
      return r;
   endfunction

   function automatic bit oob(input line_cmd_t c);
      return int'(c.x0) >= SW || int'(c.x1) >= SW || int'(c.y0) >= SH || int'(c.y1) >= SH;
   endfunction

   function automatic logic [43:0] coords(input line_cmd_t c);
      return {c.x0, c.y0, c.x1, c.y1};
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_cur = '0; m_ph = P_IDLE; m_cnt = 0; m_lines = '0; m_drop = 0; m_tout = 0;
   endtask

   task automatic model_edge(input bit v, input line_cmd_t c, input bit d);
      int sz;
      sz = m_q.size();
      case (m_ph)
         P_IDLE: if (sz != 0) m_ph = P_LOAD;
         P_LOAD: begin m_cur = m_q.pop_front(); m_cnt = 0; m_ph = P_RUN; end
         P_RUN: begin
            if (d) begin m_lines = m_lines + 16'd1; m_ph = P_IDLE; end
            else if (m_cnt == TO - 1) begin m_tout = 1; m_ph = P_IDLE; end
            m_cnt++;
         end
         default: ;
      endcase
      if (v && sz < DEPTH) begin
         if (oob(c)) m_drop = 1;
         else m_q.push_back(c);
      end
   endtask

   task automatic check_model();
      chk("cmd_ready",   bus.cmd_ready, m_q.size() < DEPTH);
      chk("drw_reset",   bus.drw_reset, m_ph != P_RUN);
      chk("busy",        busy, (m_q.size() != 0) || (m_ph != P_IDLE));
      chk("drw_coords",  {bus.drw_x0, bus.drw_y0, bus.drw_x1, bus.drw_y1}, coords(m_cur));
      chk("pix_color",   bus.pix_color, m_cur.color);
      chk("lines_done",  lines_done, m_lines);
      chk("dropped",     dropped, m_drop);
      chk("timeout_err", timeout_err, m_tout);
   endtask

   // One clock: drive inputs, let the edge happen, compare on the falling edge.
   task automatic step(input bit v, input line_cmd_t c, input bit d, output bit acc);
      bus.cmd_valid = v;
      bus.cmd_x0 = c.x0; bus.cmd_y0 = c.y0; bus.cmd_x1 = c.x1; bus.cmd_y1 = c.y1;
      bus.cmd_color = c.color;
      bus.drw_done = d;
      acc = v && bus.cmd_ready;
      @(posedge clk);
      model_edge(v, c, d);
      @(negedge clk);
      check_model();
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(0, '0, 0, a);
   endtask

   task automatic wait_run();
      int n;
      n = 0;
      while (bus.drw_reset !== 1'b0 && n < 20) begin idle(1); n++; end
      chk("run_entry", bus.drw_reset, 1'b0);
   endtask

   typedef struct {
      bit          v;
      line_cmd_t   c;
      bit          d;
      bit          e_drst;
      bit          e_busy;
      logic [15:0] e_lines;
      logic [43:0] e_drw;
   } vec_t;

   vec_t      tbl[6];
   line_cmd_t bp[6];
   line_cmd_t got[$];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit   a;
      int   n, acc_n, idx;
      logic prev;
      line_cmd_t c, ln;

      bus.cmd_valid = 0; bus.cmd_x0 = '0; bus.cmd_y0 = '0; bus.cmd_x1 = '0;
      bus.cmd_y1 = '0; bus.cmd_color = 0; bus.drw_done = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst cmd_ready",   bus.cmd_ready, 1'b1);
      chk("rst drw_reset",   bus.drw_reset, 1'b1);
      chk("rst busy",        busy, 1'b0);
      chk("rst drw_coords",  {bus.drw_x0, bus.drw_y0, bus.drw_x1, bus.drw_y1}, 44'd0);
      chk("rst pix_color",   bus.pix_color, 1'b0);
      chk("rst lines_done",  lines_done, 16'd0);
      chk("rst dropped",     dropped, 1'b0);
      chk("rst timeout_err", timeout_err, 1'b0);
      reset_n = 1'b1;
      idle(2);

      // Single line, cycle by cycle.
      ln = mk(10, 20, 100, 20, 1);
      tbl[0] = '{1, ln, 0, 1, 1, 16'd0, 44'd0};
      tbl[1] = '{0, '0, 0, 1, 1, 16'd0, 44'd0};
      tbl[2] = '{0, '0, 0, 0, 1, 16'd0, {11'd10, 11'd20, 11'd100, 11'd20}};
      tbl[3] = '{0, '0, 0, 0, 1, 16'd0, {11'd10, 11'd20, 11'd100, 11'd20}};
      tbl[4] = '{0, '0, 1, 1, 0, 16'd1, {11'd10, 11'd20, 11'd100, 11'd20}};
      tbl[5] = '{0, '0, 0, 1, 0, 16'd1, {11'd10, 11'd20, 11'd100, 11'd20}};
      for (int i = 0; i < 6; i++) begin
         step(tbl[i].v, tbl[i].c, tbl[i].d, a);
         chk($sformatf("tbl[%0d] drw_reset", i), bus.drw_reset, tbl[i].e_drst);
         chk($sformatf("tbl[%0d] busy", i), busy, tbl[i].e_busy);
         chk($sformatf("tbl[%0d] lines_done", i), lines_done, tbl[i].e_lines);
         chk($sformatf("tbl[%0d] drw", i),
             {bus.drw_x0, bus.drw_y0, bus.drw_x1, bus.drw_y1}, tbl[i].e_drw);
      end
      chk("single pix_color", bus.pix_color, 1'b1);

      // done arrives in the same cycle the timeout would fire.
      step(1, mk(1, 2, 3, 4, 0), 0, a);
      wait_run();
      idle(TO - 1);
      chk("race still running", bus.drw_reset, 1'b0);
      step(0, '0, 1, a);
      chk("race lines_done", lines_done, 16'd2);
      chk("race timeout_err", timeout_err, 1'b0);

      // Off-screen command is discarded.
      step(1, mk(700, 5, 10, 5, 1), 0, a);
      chk("offscreen dropped", dropped, 1'b1);
      chk("offscreen busy", busy, 1'b0);
      idle(3);
      chk("offscreen busy later", busy, 1'b0);

      // Timeout with done never asserted.
      step(1, mk(5, 6, 7, 8, 1), 0, a);
      wait_run();
      n = 0;
      while (bus.drw_reset === 1'b0 && n < 100) begin idle(1); n++; end
      chk("timeout run cycles", n, TO);
      chk("timeout timeout_err", timeout_err, 1'b1);
      chk("timeout lines_done", lines_done, 16'd2);

      // Backpressure with the drawer stalled; lines drain by timeout.
      idle(2);
      for (int i = 0; i < 6; i++) bp[i] = mk(100 + i, 10 + i, 200 + i, 30 + i, i[0]);
      acc_n = 0; idx = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         step(idx < 6, bp[idx < 6 ? idx : 5], 0, a);
         if (a) begin acc_n++; idx++; end
      end
      chk("backpressure accepted", acc_n, 5);
      chk("backpressure cmd_ready", bus.cmd_ready, 1'b0);
      got.delete();
      got.push_back(m_cur);
      chk("backpressure first running", {bus.drw_x0, bus.drw_y0, bus.drw_x1, bus.drw_y1},
          coords(bp[0]));
      prev = bus.drw_reset;
      n = 0;
      while ((got.size() < 5 || busy) && n < 300) begin
         idle(1);
         if (prev === 1'b1 && bus.drw_reset === 1'b0)
            got.push_back(mk(bus.drw_x0, bus.drw_y0, bus.drw_x1, bus.drw_y1, bus.pix_color));
         prev = bus.drw_reset;
         n++;
      end
      chk("backpressure lines issued", got.size(), 5);
      for (int i = 0; i < 5 && i < got.size(); i++)
         chk($sformatf("backpressure order[%0d]", i), got[i], bp[i]);

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         c.x0 = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(SW, 2047)) : 11'($urandom_range(0, SW - 1));
         c.x1 = 11'($urandom_range(0, SW - 1));
         c.y0 = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(SH, 2047)) : 11'($urandom_range(0, SH - 1));
         c.y1 = 11'($urandom_range(0, SH - 1));
         c.color = 1'($urandom_range(0, 1));
         step(1'($urandom_range(0, 1)), c, $urandom_range(0, 5) == 0, a);
      end

      // Asynchronous reset in the middle of a line with two queued behind it.
      n = 0;
      while (busy && n < 300) begin idle(1); n++; end
      chk("drain before reset", busy, 1'b0);
      step(1, mk(1, 1, 2, 2, 1), 0, a);
      step(1, mk(3, 3, 4, 4, 0), 0, a);
      step(1, mk(5, 5, 6, 6, 1), 0, a);
      wait_run();
      #2 reset_n = 1'b0;
      #1;
      chk("async rst drw_reset", bus.drw_reset, 1'b1);
      chk("async rst busy", busy, 1'b0);
      chk("async rst lines_done", lines_done, 16'd0);
      chk("async rst cmd_ready", bus.cmd_ready, 1'b1);
      chk("async rst drw_coords", {bus.drw_x0, bus.drw_y0, bus.drw_x1, bus.drw_y1}, 44'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      idle(6);
      chk("post rst no load", bus.drw_reset, 1'b1);
      chk("post rst idle", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
